// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   memReq   : read request, held high until memReady
//   memAddr  : 15-bit word address
//   memReady : read data valid this cycle
//   memData  : 16-bit instruction word
// master = fetch unit, slave = instruction memory.
interface instruction_fetch_if;
  logic        memReq;
  logic [14:0] memAddr;
  logic        memReady;
  logic [15:0] memData;

  modport master (output memReq, output memAddr, input memReady, input memData);
  modport slave  (input memReq, input memAddr, output memReady, output memData);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC register, reads instruction memory
// over a req/ready handshake and presents instruction + PC to decode.
// The PC adder computes the next address and returns it on nextPCIn.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   nextPCIn        : next fetch address, taken when HOLD consumes
//   stall           : hold the presented instruction
//   flush, flushPC  : one-cycle redirect request and its target
//   mem             : instruction memory bus (master side)
//   instructionOut  : instruction word to decode (NOP_INSTR in bubbles)
//   currentPCOut    : byte address of instructionOut
//   validOut        : instructionOut is a real fetched word
//   misaligned      : sticky, a fetch address had bit0 set
//   fetchTimeout    : sticky, a read waited MAX_WAIT cycles
//   fetchCount      : consumed instructions, modulo 2^16
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 nextPCIn,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [15:0]                 flushPC,
  instruction_fetch_if.master         mem,
  output logic [15:0]                 instructionOut,
  output logic [15:0]                 currentPCOut,
  output logic                        validOut,
  output logic                        misaligned,
  output logic                        fetchTimeout,
  output logic [15:0]                 fetchCount
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] cur_pc_q, cur_pc_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  wait_q, wait_d;
  logic        pend_flush_q, pend_flush_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        enter_fetch_s;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    cur_pc_d      = cur_pc_q;
    valid_d       = valid_q;
    timeout_d     = timeout_q;
    count_d       = count_q;
    wait_d        = wait_q;
    pend_flush_d  = pend_flush_q;
    pend_pc_d     = pend_pc_q;
    enter_fetch_s = 1'b0;

    case (state_q)
      IDLE: begin
        state_d       = FETCH;
        enter_fetch_s = 1'b1;
      end
      FETCH: begin
        if (mem.memReady) begin
          wait_d = 8'd0;
          // A redirect seen during (or on the same cycle as) the read
          // discards the word; a flush this cycle overrides an older one.
          if (pend_flush_q || flush) begin
            pc_d          = flush ? flushPC : pend_pc_q;
            pend_flush_d  = 1'b0;
            enter_fetch_s = 1'b1;
          end else begin
            instr_d  = mem.memData;
            cur_pc_d = pc_q;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end else begin
          // Saturating wait counter; the block keeps waiting after timeout.
          if (wait_q >= (MAX_WAIT_C - 8'd1)) begin
            wait_d    = MAX_WAIT_C;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
          if (flush) begin
            pend_flush_d = 1'b1;
            pend_pc_d    = flushPC;
          end else begin
            pend_flush_d = pend_flush_q;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d          = flushPC;
          valid_d       = 1'b0;
          instr_d       = NOP_INSTR;
          state_d       = FETCH;
          enter_fetch_s = 1'b1;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          pc_d          = nextPCIn;
          count_d       = count_q + 16'd1;
          valid_d       = 1'b0;
          instr_d       = NOP_INSTR;
          state_d       = FETCH;
          enter_fetch_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Misalignment is judged on the address a new fetch starts with.
    if (enter_fetch_s && pc_d[0]) begin
      misaligned_d = 1'b1;
    end else begin
      misaligned_d = misaligned_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      cur_pc_q     <= 16'hFFFE;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= 16'd0;
      wait_q       <= 8'd0;
      pend_flush_q <= 1'b0;
      pend_pc_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      cur_pc_q     <= cur_pc_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      pend_flush_q <= pend_flush_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Request decodes from state so it drops immediately on reset.
  assign mem.memReq  = (state_q == FETCH);
  assign mem.memAddr = pc_q[15:1];

  assign instructionOut = instr_q;
  assign currentPCOut   = cur_pc_q;
  assign validOut       = valid_q;
  assign misaligned     = misaligned_q;
  assign fetchTimeout   = timeout_q;
  assign fetchCount     = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] nextPCIn;
  logic        stall;
  logic        flush;
  logic [15:0] flushPC;
  logic [15:0] instructionOut;
  logic [15:0] currentPCOut;
  logic        validOut;
  logic        misaligned;
  logic        fetchTimeout;
  logic [15:0] fetchCount;

  int checks = 0;
  int errors = 0;

  instruction_fetch_if mem_bus ();

  instruction_fetch #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800),
    .MAX_WAIT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .nextPCIn      (nextPCIn),
    .stall         (stall),
    .flush         (flush),
    .flushPC       (flushPC),
    .mem           (mem_bus.master),
    .instructionOut(instructionOut),
    .currentPCOut  (currentPCOut),
    .validOut      (validOut),
    .misaligned    (misaligned),
    .fetchTimeout  (fetchTimeout),
    .fetchCount    (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs of a cycle spent presenting a bubble while a read is outstanding.
  task automatic chk_fetch(input string tag, input logic [14:0] addr);
    chk({tag, ".req"},   32'(mem_bus.memReq), 32'd1);
    chk({tag, ".addr"},  32'(mem_bus.memAddr), 32'(addr));
    chk({tag, ".valid"}, 32'(validOut), 32'd0);
    chk({tag, ".instr"}, 32'(instructionOut), 32'h0800);
  endtask

  task automatic chk_hold(input string tag, input logic [15:0] instr, input logic [15:0] pc);
    chk({tag, ".req"},   32'(mem_bus.memReq), 32'd0);
    chk({tag, ".valid"}, 32'(validOut), 32'd1);
    chk({tag, ".instr"}, 32'(instructionOut), 32'(instr));
    chk({tag, ".pc"},    32'(currentPCOut), 32'(pc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},   32'(mem_bus.memReq), 32'd0);
    chk({tag, ".addr"},  32'(mem_bus.memAddr), 32'd0);
    chk({tag, ".instr"}, 32'(instructionOut), 32'h0800);
    chk({tag, ".pc"},    32'(currentPCOut), 32'hFFFE);
    chk({tag, ".valid"}, 32'(validOut), 32'd0);
    chk({tag, ".mis"},   32'(misaligned), 32'd0);
    chk({tag, ".tmo"},   32'(fetchTimeout), 32'd0);
    chk({tag, ".cnt"},   32'(fetchCount), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    nextPCIn = 16'h0000;
    stall = 1'b0;
    flush = 1'b0;
    flushPC = 16'h0000;
    mem_bus.memReady = 1'b0;
    mem_bus.memData = 16'h0000;

    // Reset state, then IDLE for one cycle, then FETCH at RESET_PC.
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;
    step();
    chk_fetch("first", 15'h0000);

    // Zero-wait memory: word appears the cycle after memReady.
    mem_bus.memReady = 1'b1;
    mem_bus.memData = 16'h4801;
    nextPCIn = 16'h0002;
    step();
    mem_bus.memReady = 1'b0;
    chk_hold("first", 16'h4801, 16'h0000);
    chk("first.cnt", 32'(fetchCount), 32'd0);

    // Consume; memReady delayed 3 cycles -> four bubble cycles.
    step();
    chk("cons.cnt", 32'(fetchCount), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_fetch("cons", 15'h0001);
      if (i == 3) begin
        mem_bus.memReady = 1'b1;
        mem_bus.memData = 16'h1234;
      end
      stall = (i == 3);
      nextPCIn = 16'h0010;
      step();
    end
    mem_bus.memReady = 1'b0;
    chk_hold("cons", 16'h1234, 16'h0002);

    // Stall 5 cycles in HOLD while nextPCIn moves.
    for (int i = 0; i < 5; i++) begin
      nextPCIn = 16'(16'h0010 + 16'(2 * i));
      step();
      chk_hold("stall", 16'h1234, 16'h0002);
      chk("stall.addr", 32'(mem_bus.memAddr), 32'h0001);
      chk("stall.cnt", 32'(fetchCount), 32'd1);
    end
    stall = 1'b0;
    nextPCIn = 16'h0020;
    step();
    chk_fetch("unstall", 15'h0010);
    chk("unstall.cnt", 32'(fetchCount), 32'd2);
    mem_bus.memReady = 1'b1;
    mem_bus.memData = 16'h2222;
    step();
    mem_bus.memReady = 1'b0;
    chk_hold("unstall", 16'h2222, 16'h0020);

    // Flush in the first cycle of a 3-cycle wait.
    nextPCIn = 16'h0030;
    step();
    chk_fetch("fl.c1", 15'h0018);
    flush = 1'b1;
    flushPC = 16'h0040;
    step();
    flush = 1'b0;
    chk_fetch("fl.c2", 15'h0018);
    step();
    chk_fetch("fl.c3", 15'h0018);
    mem_bus.memReady = 1'b1;
    mem_bus.memData = 16'hDEAD;
    step();
    chk_fetch("fl.refetch", 15'h0020);
    mem_bus.memData = 16'h3333;
    step();
    mem_bus.memReady = 1'b0;
    chk_hold("fl", 16'h3333, 16'h0040);
    chk("fl.cnt", 32'(fetchCount), 32'd3);

    // Misaligned fetch with memReady withheld 10 cycles.
    nextPCIn = 16'h0005;
    step();
    chk_fetch("mis", 15'h0002);
    chk("mis.flag", 32'(misaligned), 32'd1);
    chk("mis.tmo0", 32'(fetchTimeout), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("tmo.w%0d", i), 32'(fetchTimeout), (i >= 8) ? 32'd1 : 32'd0);
    end
    mem_bus.memReady = 1'b1;
    mem_bus.memData = 16'h5555;
    step();
    mem_bus.memReady = 1'b0;
    chk_hold("tmo", 16'h5555, 16'h0005);
    chk("tmo.sticky", 32'(fetchTimeout), 32'd1);
    chk("mis.sticky", 32'(misaligned), 32'd1);

    // Flush in HOLD beats consume and does not count.
    flush = 1'b1;
    flushPC = 16'h0100;
    step();
    flush = 1'b0;
    chk_fetch("hflush", 15'h0080);
    chk("hflush.cnt", 32'(fetchCount), 32'd4);

    // Flush together with memReady: data discarded, flushPC fetched next.
    flush = 1'b1;
    flushPC = 16'h0200;
    mem_bus.memReady = 1'b1;
    mem_bus.memData = 16'hBAD0;
    step();
    flush = 1'b0;
    chk_fetch("flrdy", 15'h0100);
    mem_bus.memData = 16'h7777;
    step();
    mem_bus.memReady = 1'b0;
    chk_hold("flrdy", 16'h7777, 16'h0200);

    // Reset mid-FETCH.
    nextPCIn = 16'h0300;
    step();
    chk_fetch("prerst", 15'h0180);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst1");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk_fetch("postrst", 15'h0000);
    mem_bus.memReady = 1'b1;
    mem_bus.memData = 16'h1111;
    stall = 1'b1;
    step();
    mem_bus.memReady = 1'b0;
    chk_hold("postrst", 16'h1111, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side partner of the PC adder: owns the PC register, issues instruction reads to instruction memory over a req/ready handshake, and presents instruction + PC to decode.
- Decode/jump logic feeds the fetched instruction and PC into the PC adder, whose nextPC returns here as the next fetch address.
- Inserts NOP bubbles while a fetch is outstanding; supports hazard stall and an external redirect (flush).

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INSTR, 16'h0800, instruction word driven during bubbles and reset.
- MAX_WAIT, 8, memory wait cycles before timeout flag sets (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- nextPCIn  in  16  next fetch address from PC adder, sampled on consume.
- stall  in  1  decode/hazard stall; holds the current instruction.
- flush  in  1  redirect request, one-cycle pulse.
- flushPC  in  16  redirect target, valid with flush.
- memReq  out  1  instruction read request.
- memAddr  out  15  word address = pcReg[15:1].
- memReady  in  1  read data valid this cycle.
- memData  in  16  instruction word.
- instructionOut  out  16  instruction to decode/PC adder.
- currentPCOut  out  16  byte address of instructionOut.
- validOut  out  1  instructionOut is a real fetched instruction.
- misaligned  out  1  sticky: a fetch address had bit0 = 1.
- fetchTimeout  out  1  sticky: a read waited >= MAX_WAIT cycles.
- fetchCount  out  16  count of consumed instructions, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - state = IDLE; pcReg = RESET_PC; memReq = 0.
  - instructionOut = NOP_INSTR; currentPCOut = 16'hFFFE; validOut = 0.
  - misaligned = 0; fetchTimeout = 0; fetchCount = 0; wait counter = 0; pendFlush = 0.
- All outputs are registered except memReq/memAddr, which decode from state/pcReg.
- States:
  - IDLE: one cycle after reset release -> FETCH.
  - FETCH: memReq = 1, memAddr = pcReg[15:1], validOut = 0, instructionOut = NOP_INSTR.
    - On memReady with pendFlush = 0: instructionOut <= memData, currentPCOut <= pcReg, validOut <= 1 -> HOLD.
    - On memReady with pendFlush = 1: discard data, pcReg <= pendPC, pendFlush <= 0, stay in FETCH (new request the next cycle).
  - HOLD: memReq = 0; the instruction stays stable.
    - flush: pcReg <= flushPC, validOut <= 0, instructionOut <= NOP_INSTR -> FETCH; fetchCount not incremented.
    - else stall: hold everything.
    - else consume: pcReg <= nextPCIn, fetchCount += 1, validOut <= 0, instructionOut <= NOP_INSTR -> FETCH.
- Priority in HOLD: flush > stall > consume.
- flush during FETCH: the request is not abandoned; memReq stays high until memReady. Latch pendFlush = 1, pendPC = flushPC. A later flush before memReady overwrites pendPC.
- flush and memReady in the same FETCH cycle: treat as pendFlush (data discarded, fetch flushPC next).
- Minimum latency from request to validOut is 1 cycle after memReady (registered). Minimum loop with zero-wait memory: FETCH -> HOLD -> FETCH, i.e. one instruction per 2 cycles.
- Wait counter (8-bit):
  - Increments each FETCH cycle without memReady and saturates at MAX_WAIT.
  - Reaching MAX_WAIT sets fetchTimeout; the block keeps waiting.
  - Cleared on memReady.
- misaligned: set when pcReg[0] = 1 at FETCH entry. The fetch proceeds with memAddr = pcReg[15:1] and currentPCOut carries the odd value unchanged.
- memReady outside FETCH is ignored.
- Arithmetic: no PC increment here (the PC adder owns it). fetchCount is unsigned modulo 2^16.

Test Plan:
- Reset then zero-wait memory returning 16'h4801 at addr 0: memReq rises cycle 2, memAddr = 0; the next cycle instructionOut = 16'h4801, currentPCOut = 16'h0000, validOut = 1.
- Consume with nextPCIn = 16'h0002, memReady delayed 3 cycles: validOut = 0 and instructionOut = 16'h0800 for 4 cycles, memAddr = 15'h0001, fetchCount = 1.
- stall held 5 cycles in HOLD with nextPCIn changing: instructionOut/currentPCOut unchanged, no memReq, pcReg unchanged; release -> fetches latest nextPCIn.
- flush (flushPC = 16'h0040) in FETCH cycle 1 of a 3-cycle wait: first returned word discarded, validOut stays 0, a second request goes out at memAddr = 15'h0020, then validOut = 1 with currentPCOut = 16'h0040.
- memReady withheld 10 cycles with MAX_WAIT = 8: fetchTimeout = 1 after cycle 8 and stays set after completion. nextPCIn = 16'h0005 -> misaligned = 1, memAddr = 15'h0002.
- rst asserted mid-FETCH: memReq drops the same cycle; all outputs return to reset values and the next fetch goes to RESET_PC.
